// File: rtl/div_unit_if.sv
// Handshake bundle between the pipeline and the iterative divider.
// The pipeline drives the request side (master); the divider returns status and the HILO value (slave).
interface div_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// 32-cycle restoring divider for DIV/DIVU, result = {hi = remainder, lo = quotient}.
// Optional macro DIV_BYZERO_FAST_EN: a zero divisor completes via a one-cycle ZERO state.
module div_unit (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef DIV_BYZERO_FAST_EN
    , ZERO
`endif
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;       // partial remainder, always below the divisor magnitude
  logic [31:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dvs;       // divisor magnitude
  logic        q_neg;
  logic        r_neg;
  logic        dvs_zero;
  logic        busy_q;
  logic        done_q;
  logic [63:0] result_q;

  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] rem_final;
  logic [31:0] quo_final;

  // NOTE: every signal gets a value before any branch, so no latch can be inferred.
  always_comb begin
    rem_shift = {rem, quo[31]};
    rem_diff  = rem_shift - {1'b0, dvs};
    rem_step  = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
    quo_step  = {quo[30:0], ~rem_diff[32]};
    rem_final = r_neg ? -rem_step : rem_step;
    quo_final = quo_step;
    if (dvs_zero)
      quo_final = 32'hFFFF_FFFF;
    else if (q_neg)
      quo_final = -quo_step;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and counter registers are cleared too, so no stale divide survives a reset.
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvs_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.annul) begin
      // A flush abandons whatever is in flight; result keeps the last completed value.
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            quo      <= (bus.signed_div && bus.a[31]) ? -bus.a : bus.a;
            dvs      <= (bus.signed_div && bus.b[31]) ? -bus.b : bus.b;
            q_neg    <= bus.signed_div && (bus.a[31] ^ bus.b[31]);
            r_neg    <= bus.signed_div && bus.a[31];
            dvs_zero <= (bus.b == 32'd0);
            rem      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
`ifdef DIV_BYZERO_FAST_EN
            state    <= (bus.b == 32'd0) ? ZERO : RUN;
`else
            state    <= RUN;
`endif
          end
        end

        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {rem_final, quo_final};
          end
        end

`ifdef DIV_BYZERO_FAST_EN
        ZERO: begin
          // quo still holds |a|; restoring the sign gives back the raw dividend for hi.
          state    <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= {(r_neg ? -quo : quo), 32'hFFFF_FFFF};
        end
`endif

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {result, done cycle}, a monitor pops on done.
// Zero-divisor latency follows DIV_BYZERO_FAST_EN.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  div_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DIV_BYZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [63:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called #1 after a rising edge; that cycle is N. Returns #1 into cycle N+1.
  task automatic issue(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp_res, input int lat, input bit expect_done);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.a          = av;
    bus.b          = bv;
    if (expect_done) sb.push_back('{exp_res, cyc + lat});
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic run(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] exp_res, input int lat);
    @(posedge clk); #1;
    issue(sgn, av, bv, exp_res, lat, 1'b1);
    repeat (lat + 2) @(posedge clk);
    #1;
    last_res = exp_res;
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("result", bus.result, mon_e.res);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_result", bus.result, 64'h0);
    last_res = 64'h0;

    // DIVU 100/7 with busy profile N+1..N+33
    @(posedge clk); #1;
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check("busy_profile", bus.busy, (k <= 32));
    end
    last_res = {32'd2, 32'd14};
    repeat (3) @(posedge clk);
    #1;

    run(1'b1, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run(1'b0, 32'h1234_5678, 32'd0,        {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT);
    run(1'b1, 32'hFFFF_FFF0, 32'd0,        {32'hFFFF_FFF0, 32'hFFFF_FFFF}, ZLAT);
    run(1'b0, 32'hFFFF_FFFF, 32'd16,       {32'h0000_000F, 32'h0FFF_FFFF}, 33);

    // start while busy and start in DONE are both ignored
    @(posedge clk); #1;
    issue(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.signed_div = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_in_done_busy", bus.busy, 1'b0);
    last_res = {32'd0, 32'd10};
    repeat (40) @(posedge clk);
    #1;

    // annul at N+10, restart at N+12
    issue(1'b0, 32'd1000, 32'd10, 64'h0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul_busy", bus.busy, 1'b0);
    check("annul_done", bus.done, 1'b0);
    check("annul_result", bus.result, last_res);
    @(posedge clk); #1;
    issue(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 1'b1);
    repeat (35) @(posedge clk);
    #1;
    last_res = {32'd0, 32'd100};

    // annul and start together in IDLE: annul wins
    bus.annul = 1'b1;
    issue(1'b1, 32'd20, 32'd4, 64'h0, 0, 1'b0);
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul_start_busy", bus.busy, 1'b0);
    repeat (40) @(posedge clk);
    check("annul_start_result", bus.result, last_res);
    #1;

    // reset at N+5 mid-RUN, with a start pulse during RUN beforehand
    issue(1'b0, 32'd77, 32'd7, 64'h0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", bus.result, 64'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    repeat (40) @(posedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
